// File: rtl/vsd_mount_monitor.sv
// Multi-drive virtual-SD mount monitor: per-slot mount state, timed cold-reset request,
// per-slot SPI activity detection and core/virtual/physical SPI routing.
module vsd_mount_monitor #(
    parameter int unsigned        NUM_DRV        = 2,
    parameter int unsigned        ACT_TIMEOUT    = 1000000,
    parameter int unsigned        RST_HOLD       = 10000000,
    parameter logic [NUM_DRV-1:0] RESET_ON_MOUNT = {NUM_DRV{1'b1}}
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_DRV-1:0] img_mounted,
    input  logic [NUM_DRV-1:0] img_size_nz,
    input  logic [NUM_DRV-1:0] spi_ss_n,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               phys_miso,
    input  logic [NUM_DRV-1:0] virt_miso,
    output logic               core_miso,
    output logic               phys_ss_n,
    output logic               phys_sck,
    output logic               phys_mosi,
    output logic [NUM_DRV-1:0] virt_ss_n,
    output logic [NUM_DRV-1:0] vsd_sel,
    output logic               img_reset,
    output logic [NUM_DRV-1:0] act,
    output logic               led_virt,
    output logic               led_phys
);

    localparam int unsigned      CntW     = $clog2(ACT_TIMEOUT + 1);
    localparam int unsigned      HoldW    = $clog2(RST_HOLD + 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(ACT_TIMEOUT);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(RST_HOLD - 1);

    logic [NUM_DRV-1:0] vsd_sel_q, vsd_sel_d;
    logic               img_reset_q, img_reset_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [CntW-1:0]    cnt_q [NUM_DRV];
    logic [CntW-1:0]    cnt_d [NUM_DRV];
    logic               prev_mosi_q, prev_miso_q;
    logic               tog;
    logic               sel_found;

    // Mount pulses overwrite only the slots that pulse; other slots keep their state.
    assign vsd_sel_d = (vsd_sel_q & ~img_mounted) | (img_size_nz & img_mounted);

    always_comb begin
        hold_d      = hold_q;
        img_reset_d = img_reset_q;
        if (|(img_mounted & RESET_ON_MOUNT)) begin
            hold_d      = HoldLoad;
            img_reset_d = 1'b1;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HoldW'(1);
        end else begin
            img_reset_d = 1'b0;
        end
    end

    assign tog = (prev_mosi_q ^ spi_mosi) | (prev_miso_q ^ core_miso);

    always_comb begin
        act = '0;
        for (int i = 0; i < int'(NUM_DRV); i++) begin
            cnt_d[i] = cnt_q[i];
            if (tog && !spi_ss_n[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CntMax) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
            act[i] = (cnt_q[i] != CntMax);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vsd_sel_q   <= '0;
            img_reset_q <= 1'b0;
            hold_q      <= '0;
            prev_mosi_q <= 1'b1;
            prev_miso_q <= 1'b1;
            for (int i = 0; i < int'(NUM_DRV); i++) begin
                cnt_q[i] <= CntMax;
            end
        end else begin
            vsd_sel_q   <= vsd_sel_d;
            img_reset_q <= img_reset_d;
            hold_q      <= hold_d;
            prev_mosi_q <= spi_mosi;
            prev_miso_q <= core_miso;
            for (int i = 0; i < int'(NUM_DRV); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Lowest-index asserted chip select owns MISO; an unmapped slot reads as no card.
    always_comb begin
        sel_found = 1'b0;
        core_miso = 1'b1;
        for (int i = 0; i < int'(NUM_DRV); i++) begin
            if (!sel_found && !spi_ss_n[i]) begin
                sel_found = 1'b1;
                if (vsd_sel_q[i]) begin
                    core_miso = virt_miso[i];
                end else if (i == 0) begin
                    core_miso = phys_miso;
                end else begin
                    core_miso = 1'b1;
                end
            end
        end
    end

    assign virt_ss_n = spi_ss_n | ~vsd_sel_q;
    assign phys_ss_n = spi_ss_n[0] | vsd_sel_q[0];
    assign phys_sck  = spi_sck & ~phys_ss_n;
    assign phys_mosi = spi_mosi & ~phys_ss_n;

    assign vsd_sel   = vsd_sel_q;
    assign img_reset = img_reset_q;
    assign led_virt  = |(act & vsd_sel_q);
    assign led_phys  = act[0] & ~vsd_sel_q[0];

endmodule
